// File: rtl/slave_player_b.sv
// Player-B endpoint of the two-board Battleship link.
// Debounces B's buttons, holds B's fleet and committed attack, and reports
// liveness, attack legality, hit count and an attack-commit strobe.

// Single-button debouncer: 2-flop synchronizer plus a stability counter.
// Registers power up at 0 and are intentionally not tied to the game reset.
module debounce_lane #(
  parameter int DEB_CYC = 500000
) (
  input  logic clk,
  input  logic din,
  output logic q
);
  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          s1  = 1'b0;
  logic          s2  = 1'b0;
  logic          lvl = 1'b0;
  logic [CW-1:0] cnt = '0;

  // Synchronize, then toggle the level only after DEB_CYC stable cycles.
  always_ff @(posedge clk) begin
    s1 <= din;
    s2 <= s1;
    if (s2 == lvl) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYC - 1)) begin
      lvl <= ~lvl;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign q = lvl;
endmodule

module slave_player_b #(
  parameter int N       = 10,
  parameter int DEB_CYC = 500000
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] sw,
  input  logic         btn1_raw,
  input  logic         btn2_raw,
  input  logic         btn3_raw,
  input  logic [N-1:0] A_Attack,
  input  logic         ST,
  input  logic         LDR1B,
  input  logic         LDR2B,
  input  logic [2:0]   DispB,
  output logic         BTN1B,
  output logic         BTN2B,
  output logic         BTN3B,
  output logic [N-1:0] B_Attack,
  output logic         LivB,
  output logic         OKB,
  output logic         atk_stb,
  output logic [3:0]   hits,
  output logic [2:0]   disp_word,
  output logic [N-1:0] Bleds
);
  localparam int PW = $clog2(N + 1);
  localparam int SW = ((PW > 4) ? PW : 4) + 1;

  function automatic logic [PW-1:0] popcnt(input logic [N-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  logic [2:0]   btn_raw;
  logic [2:0]   btn_db;
  logic [N-1:0] ships;
  logic [N-1:0] prev_atk;
  logic         ldr2_q;
  logic [N-1:0] new_bits;
  logic         legal;
  logic         commit;
  logic [SW-1:0] hit_sum;

  assign btn_raw = {btn3_raw, btn2_raw, btn1_raw};

  // One debouncer per button.
  for (genvar g = 0; g < 3; g++) begin : g_deb
    debounce_lane #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk (clk),
      .din (btn_raw[g]),
      .q   (btn_db[g])
    );
  end

  assign BTN1B = btn_db[0];
  assign BTN2B = btn_db[1];
  assign BTN3B = btn_db[2];

  // Legal next attack: exactly one new bit and no previously fired bit dropped.
  assign new_bits = sw & ~prev_atk;
  assign legal    = (popcnt(new_bits) == PW'(1)) && ((prev_atk & ~sw) == '0);
  assign commit   = ST && LDR2B && !ldr2_q;
  assign hit_sum  = SW'(hits) + SW'(popcnt(ships & A_Attack));

  // Fleet, hit counter, attack commit and display latch; clr wins over all.
  always_ff @(posedge clk) begin
    if (clr) begin
      ships     <= '0;
      B_Attack  <= '0;
      prev_atk  <= '0;
      hits      <= '0;
      disp_word <= '0;
      OKB       <= 1'b0;
      atk_stb   <= 1'b0;
      ldr2_q    <= 1'b0;
    end else begin
      ldr2_q    <= LDR2B;
      disp_word <= DispB;
      OKB       <= ST && legal;
      atk_stb   <= commit;
      if (ST) begin
        // Hit bits are cleared on the same edge they are counted.
        ships <= ships & ~A_Attack;
        hits  <= (hit_sum > SW'(15)) ? 4'd15 : hit_sum[3:0];
      end else if (LDR1B) begin
        ships <= sw;
      end
      // Commit is taken regardless of OKB; the master gates legality.
      if (commit) begin
        B_Attack <= sw;
        prev_atk <= sw;
      end
    end
  end

  assign LivB  = |ships;
  assign Bleds = ships;
endmodule
